// File: rtl/memory_access_pkg.sv
// memory_access_pkg
//   Shared types for the LEGv8 MEM stage.
//   state_t  : data-memory access FSM states (IDLE, BUSY)
//   REG_W    : register-file index width
//   exmem_t  : EX/MEM control fields (data words are carried alongside, width N)
//   memwb_t  : MEM/WB control fields (data words are carried alongside, width N)
package memory_access_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int REG_W = 5;

    typedef struct packed {
        logic             valid;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic             reg_write;
        logic             mem_to_reg;
        logic             zero;
        logic [REG_W-1:0] write_reg;
    } exmem_t;

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] write_reg;
    } memwb_t;

endpackage

// File: rtl/memory_access_if.sv
// memory_access_if
//   Data-memory req/ack bus between the MEM stage and data memory.
//   req   : access request, held until ack
//   we    : write enable (store)
//   addr  : byte address
//   wdata : store data
//   rdata : load data, valid when ack=1
//   ack   : completes the request in the same cycle
//   modport master : MEM stage side; modport slave : memory side
interface memory_access_if #(
    parameter int N = 64
) ();
    logic         req;
    logic         we;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic [N-1:0] rdata;
    logic         ack;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/memory_access_flopr_en.sv
// flopr_en
//   Parameter-width register with load enable and asynchronous active-low reset.
//   clk   : rising-edge clock
//   reset : async, active-low; clears q
//   en    : load d on the clock edge when 1, otherwise hold
//   d / q : data in / registered data out (WIDTH bits)
module flopr_en #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/memory_access.sv
// memory_access
//   LEGv8 pipeline MEM stage. Registers EX results (EX/MEM), resolves CBZ,
//   performs LDUR/STUR over a req/ack data-memory bus, stalls upstream while an
//   access is outstanding, and feeds writeback through the MEM/WB register.
//   Optional feature macro: MEM_TIMEOUT_EN -- abort an access after
//   TIMEOUT_CYCLES BUSY cycles without ack and set the sticky mem_err flag.
// Ports
//   clk, reset          : clock (rising edge), async active-low reset
//   *_E                 : EX-stage instruction slot (controls, results, zero flag)
//   stall_M             : hold EX and earlier stages this cycle
//   PCSrc_M, PCBranch_M : branch taken / registered target
//   dm                  : data-memory bus (master side)
//   *_W                 : MEM/WB register outputs
//   mem_err             : sticky access-timeout flag (0 without MEM_TIMEOUT_EN)
module memory_access
    import memory_access_pkg::*;
#(
    parameter int N              = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_E,
    input  logic             MemRead_E,
    input  logic             MemWrite_E,
    input  logic             Branch_E,
    input  logic             RegWrite_E,
    input  logic             MemtoReg_E,
    input  logic [REG_W-1:0] writeReg_E,
    input  logic [N-1:0]     PCBranch_E,
    input  logic [N-1:0]     aluResult_E,
    input  logic [N-1:0]     writeData_E,
    input  logic             zero_E,
    output logic             stall_M,
    output logic             PCSrc_M,
    output logic [N-1:0]     PCBranch_M,
    memory_access_if.master  dm,
    output logic             valid_W,
    output logic             RegWrite_W,
    output logic             MemtoReg_W,
    output logic [REG_W-1:0] writeReg_W,
    output logic [N-1:0]     aluResult_W,
    output logic [N-1:0]     readData_W,
    output logic             mem_err
);

    localparam int EXMEM_W = $bits(exmem_t) + 3 * N;
    localparam int MEMWB_W = $bits(memwb_t) + N;

    state_t       state;
    logic         done_M;
    logic         abort;
    logic         memop_M;
    logic         req;
    logic         ack_hit;
    logic         ex_load;

    exmem_t       ctrl_E;
    exmem_t       ctrl_M;
    logic [N-1:0] alu_result_M;
    logic [N-1:0] write_data_M;
    logic [EXMEM_W-1:0] exmem_d;
    logic [EXMEM_W-1:0] exmem_q;

    memwb_t       wb_d;
    memwb_t       wb_q;
    logic [N-1:0] alu_w_d;
    logic [MEMWB_W-1:0] memwb_d;
    logic [MEMWB_W-1:0] memwb_q;

    // ---------------- EX/MEM register ----------------
    always_comb begin
        ctrl_E            = '0;
        ctrl_E.valid      = valid_E;
        ctrl_E.mem_read   = MemRead_E;
        ctrl_E.mem_write  = MemWrite_E;
        ctrl_E.branch     = Branch_E;
        ctrl_E.reg_write  = RegWrite_E;
        ctrl_E.mem_to_reg = MemtoReg_E;
        ctrl_E.zero       = zero_E;
        ctrl_E.write_reg  = writeReg_E;
    end

    assign exmem_d = {ctrl_E, PCBranch_E, aluResult_E, writeData_E};
    assign ex_load = ~stall_M;

    flopr_en #(.WIDTH(EXMEM_W)) u_exmem (
        .clk   (clk),
        .reset (reset),
        .en    (ex_load),
        .d     (exmem_d),
        .q     (exmem_q)
    );

    assign {ctrl_M, PCBranch_M, alu_result_M, write_data_M} = exmem_q;

    // ---------------- data-memory request ----------------
    assign memop_M = ctrl_M.valid & (ctrl_M.mem_read | ctrl_M.mem_write);
    // abort gates the request off in the timeout cycle so stall releases and
    // the instruction retires in the same cycle.
    assign req     = memop_M & ~done_M & ~abort;
    assign ack_hit = req & dm.ack;
    assign stall_M = req & ~dm.ack;

    assign dm.req   = req;
    assign dm.we    = req & ctrl_M.mem_write;
    assign dm.addr  = alu_result_M;
    assign dm.wdata = write_data_M;

    assign PCSrc_M = ctrl_M.valid & ctrl_M.branch & ctrl_M.zero & ~stall_M;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] busy_cnt;
    logic             mem_err_q;

    assign abort   = (state == BUSY) && (busy_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign mem_err = mem_err_q;
`else
    assign abort   = 1'b0;
    assign mem_err = 1'b0;
`endif

    // ---------------- access FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            done_M    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            busy_cnt  <= '0;
            mem_err_q <= 1'b0;
`endif
        end else begin
            if (ex_load) begin
                done_M <= 1'b0;
            end else if (ack_hit) begin
                done_M <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req && !dm.ack) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // Request gone (ack or abort) returns to IDLE.
                    if (ack_hit || !req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef MEM_TIMEOUT_EN
            if (state == BUSY && !ack_hit && !abort) begin
                busy_cnt <= busy_cnt + 1'b1;
            end else begin
                busy_cnt <= '0;
            end
            if (abort) begin
                mem_err_q <= 1'b1;
            end
`endif
        end
    end

    // ---------------- MEM/WB register ----------------
    always_comb begin
        wb_d    = '0;
        alu_w_d = '0;
        if (!stall_M) begin
            wb_d.valid      = ctrl_M.valid;
            wb_d.reg_write  = ctrl_M.reg_write & ~abort;
            wb_d.mem_to_reg = ctrl_M.mem_to_reg;
            wb_d.write_reg  = ctrl_M.write_reg;
            alu_w_d         = alu_result_M;
        end
    end

    assign memwb_d = {wb_d, alu_w_d};

    flopr_en #(.WIDTH(MEMWB_W)) u_memwb (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (memwb_d),
        .q     (memwb_q)
    );

    assign {wb_q, aluResult_W} = memwb_q;
    assign valid_W    = wb_q.valid;
    assign RegWrite_W = wb_q.reg_write;
    assign MemtoReg_W = wb_q.mem_to_reg;
    assign writeReg_W = wb_q.write_reg;

    // Load data is captured only in the cycle the request is acknowledged.
    flopr_en #(.WIDTH(N)) u_rdata (
        .clk   (clk),
        .reset (reset),
        .en    (ack_hit),
        .d     (dm.rdata),
        .q     (readData_W)
    );

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;
    import memory_access_pkg::*;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_E, MemRead_E, MemWrite_E, Branch_E, RegWrite_E, MemtoReg_E, zero_E;
    logic [4:0]   writeReg_E;
    logic [N-1:0] PCBranch_E, aluResult_E, writeData_E;
    logic         stall_M, PCSrc_M;
    logic [N-1:0] PCBranch_M;
    logic         valid_W, RegWrite_W, MemtoReg_W, mem_err;
    logic [4:0]   writeReg_W;
    logic [N-1:0] aluResult_W, readData_W;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    memory_access_if #(.N(N)) dm ();

    memory_access #(.N(N), .TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_E     (valid_E),
        .MemRead_E   (MemRead_E),
        .MemWrite_E  (MemWrite_E),
        .Branch_E    (Branch_E),
        .RegWrite_E  (RegWrite_E),
        .MemtoReg_E  (MemtoReg_E),
        .writeReg_E  (writeReg_E),
        .PCBranch_E  (PCBranch_E),
        .aluResult_E (aluResult_E),
        .writeData_E (writeData_E),
        .zero_E      (zero_E),
        .stall_M     (stall_M),
        .PCSrc_M     (PCSrc_M),
        .PCBranch_M  (PCBranch_M),
        .dm          (dm),
        .valid_W     (valid_W),
        .RegWrite_W  (RegWrite_W),
        .MemtoReg_W  (MemtoReg_W),
        .writeReg_W  (writeReg_W),
        .aluResult_W (aluResult_W),
        .readData_W  (readData_W),
        .mem_err     (mem_err)
    );

    typedef struct {
        logic        valid, mr, mw, br, rw, m2r, zero, ack;
        logic [4:0]  wr;
        logic [63:0] pcb, alu, wd, rdata;
        logic        e_req, e_we, e_stall, e_pcsrc;
        logic        e_vw, e_rww, e_m2rw;
        logic        chk_rd;
        logic [63:0] e_rd;
    } vec_t;

    vec_t tv[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_e(input logic v, input logic mr, input logic mw, input logic br,
                         input logic rw, input logic m2r, input logic z, input logic [4:0] wr,
                         input logic [63:0] pcb, input logic [63:0] alu, input logic [63:0] wd);
        valid_E = v; MemRead_E = mr; MemWrite_E = mw; Branch_E = br;
        RegWrite_E = rw; MemtoReg_E = m2r; zero_E = z; writeReg_E = wr;
        PCBranch_E = pcb; aluResult_E = alu; writeData_E = wd;
    endtask

    task automatic idle_e();
        set_e(0, 0, 0, 0, 0, 0, 0, 5'd0, 64'd0, 64'd0, 64'd0);
    endtask

    function automatic vec_t mk(input logic v, input logic mr, input logic mw, input logic br,
                                input logic rw, input logic m2r, input logic z, input logic ack,
                                input logic [4:0] wr, input logic [63:0] pcb, input logic [63:0] alu,
                                input logic [63:0] wd, input logic [63:0] rd,
                                input logic e_req, input logic e_we, input logic e_pcsrc,
                                input logic e_vw, input logic e_rww, input logic e_m2rw,
                                input logic chk_rd, input logic [63:0] e_rd);
        vec_t t;
        t.valid = v; t.mr = mr; t.mw = mw; t.br = br; t.rw = rw; t.m2r = m2r; t.zero = z;
        t.ack = ack; t.wr = wr; t.pcb = pcb; t.alu = alu; t.wd = wd; t.rdata = rd;
        t.e_req = e_req; t.e_we = e_we; t.e_stall = 1'b0; t.e_pcsrc = e_pcsrc;
        t.e_vw = e_vw; t.e_rww = e_rww; t.e_m2rw = e_m2rw; t.chk_rd = chk_rd; t.e_rd = e_rd;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;

        //            v mr mw br rw m2r z ack wr     pcb      alu      wd       rdata    req we pc vw rww m2r crd rd
        tv[0] = mk(1, 0, 0, 0, 1, 0, 0, 0, 5'd3, 64'h0,   64'h55,  64'h0,    64'h0,    0, 0, 0, 1, 1, 0, 0, 64'h0);
        tv[1] = mk(1, 0, 1, 0, 0, 0, 0, 1, 5'd2, 64'h0,   64'h80,  64'h1234, 64'h0,    1, 1, 0, 1, 0, 0, 0, 64'h0);
        tv[2] = mk(1, 1, 0, 0, 1, 1, 0, 1, 5'd5, 64'h0,   64'h48,  64'h0,    64'hBEEF, 1, 0, 0, 1, 1, 1, 1, 64'hBEEF);
        tv[3] = mk(1, 0, 0, 1, 0, 0, 1, 0, 5'd0, 64'h100, 64'h0,   64'h0,    64'h0,    0, 0, 1, 1, 0, 0, 0, 64'h0);
        tv[4] = mk(1, 0, 0, 1, 0, 0, 0, 0, 5'd0, 64'h200, 64'h1,   64'h0,    64'h0,    0, 0, 0, 1, 0, 0, 0, 64'h0);
        tv[5] = mk(0, 1, 0, 0, 0, 0, 0, 1, 5'd0, 64'h0,   64'h99,  64'h0,    64'h7777, 0, 0, 0, 0, 0, 0, 1, 64'hBEEF);
        tv[6] = mk(0, 0, 0, 1, 0, 0, 1, 0, 5'd0, 64'h300, 64'h0,   64'h0,    64'h0,    0, 0, 0, 0, 0, 0, 0, 64'h0);

        reset = 1'b0;
        idle_e();
        dm.ack = 1'b0;
        dm.rdata = '0;
        #2;
        chk("rst_stall", stall_M, 0);
        chk("rst_pcsrc", PCSrc_M, 0);
        chk("rst_pcbranch", PCBranch_M, 0);
        chk("rst_req", dm.req, 0);
        chk("rst_we", dm.we, 0);
        chk("rst_addr", dm.addr, 0);
        chk("rst_wdata", dm.wdata, 0);
        chk("rst_valid_w", valid_W, 0);
        chk("rst_regwrite_w", RegWrite_W, 0);
        chk("rst_memtoreg_w", MemtoReg_W, 0);
        chk("rst_writereg_w", writeReg_W, 0);
        chk("rst_alu_w", aluResult_W, 0);
        chk("rst_rdata_w", readData_W, 0);
        chk("rst_mem_err", mem_err, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single-instruction vectors, each followed by a bubble.
        for (int i = 0; i < 7; i++) begin
            set_e(tv[i].valid, tv[i].mr, tv[i].mw, tv[i].br, tv[i].rw, tv[i].m2r,
                  tv[i].zero, tv[i].wr, tv[i].pcb, tv[i].alu, tv[i].wd);
            tick();
            idle_e();
            dm.ack = tv[i].ack;
            dm.rdata = tv[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), dm.req, tv[i].e_req);
            chk($sformatf("v%0d_we", i), dm.we, tv[i].e_we);
            chk($sformatf("v%0d_stall", i), stall_M, tv[i].e_stall);
            chk($sformatf("v%0d_pcsrc", i), PCSrc_M, tv[i].e_pcsrc);
            chk($sformatf("v%0d_pcbranch", i), PCBranch_M, tv[i].pcb);
            if (tv[i].e_req) begin
                chk($sformatf("v%0d_addr", i), dm.addr, tv[i].alu);
                chk($sformatf("v%0d_wdata", i), dm.wdata, tv[i].wd);
            end
            tick();
            dm.ack = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_pcsrc_after", i), PCSrc_M, 0);
            chk($sformatf("v%0d_valid_w", i), valid_W, tv[i].e_vw);
            chk($sformatf("v%0d_regwrite_w", i), RegWrite_W, tv[i].e_rww);
            chk($sformatf("v%0d_memtoreg_w", i), MemtoReg_W, tv[i].e_m2rw);
            chk($sformatf("v%0d_writereg_w", i), writeReg_W, tv[i].wr);
            chk($sformatf("v%0d_alu_w", i), aluResult_W, tv[i].alu);
            if (tv[i].chk_rd) chk($sformatf("v%0d_rdata_w", i), readData_W, tv[i].e_rd);
        end

        // LDUR with ack after three wait cycles; ADD waits in EX behind it.
        set_e(1, 1, 0, 0, 1, 1, 0, 5'd7, 64'h0, 64'h40, 64'h0);
        tick();
        set_e(1, 0, 0, 0, 1, 0, 0, 5'd9, 64'h0, 64'h77, 64'h0);
        dm.ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ld_wait%0d_stall", k), stall_M, 1);
            chk($sformatf("ld_wait%0d_req", k), dm.req, 1);
            chk($sformatf("ld_wait%0d_addr", k), dm.addr, 64'h40);
            chk($sformatf("ld_wait%0d_we", k), dm.we, 0);
            if (k > 0) chk($sformatf("ld_wait%0d_bubble", k), valid_W, 0);
            tick();
        end
        dm.ack = 1'b1;
        dm.rdata = 64'hDEAD;
        @(negedge clk);
        chk("ld_ack_stall", stall_M, 0);
        chk("ld_ack_req", dm.req, 1);
        chk("ld_ack_addr", dm.addr, 64'h40);
        chk("ld_ack_bubble", valid_W, 0);
        tick();
        dm.ack = 1'b0;
        idle_e();
        @(negedge clk);
        chk("ld_rdata_w", readData_W, 64'hDEAD);
        chk("ld_regwrite_w", RegWrite_W, 1);
        chk("ld_memtoreg_w", MemtoReg_W, 1);
        chk("ld_valid_w", valid_W, 1);
        chk("ld_writereg_w", writeReg_W, 7);
        chk("ld_next_req", dm.req, 0);
        tick();
        @(negedge clk);
        chk("ld_next_writereg_w", writeReg_W, 9);
        chk("ld_next_alu_w", aluResult_W, 64'h77);
        chk("ld_next_regwrite_w", RegWrite_W, 1);
        chk("ld_next_memtoreg_w", MemtoReg_W, 0);

        // Back-to-back zero-wait LDURs: one retire per cycle.
        for (int k = 0; k < 4; k++) begin
            set_e(1, 1, 0, 0, 1, 1, 0, 5'(10 + k), 64'h0, 64'(64'h200 + 8 * k), 64'h0);
            tick();
            dm.ack = 1'b1;
            dm.rdata = 64'(64'hA000 + k);
            @(negedge clk);
            chk($sformatf("b2b%0d_stall", k), stall_M, 0);
            chk($sformatf("b2b%0d_req", k), dm.req, 1);
            chk($sformatf("b2b%0d_addr", k), dm.addr, 64'(64'h200 + 8 * k));
            if (k > 0) begin
                chk($sformatf("b2b%0d_writereg_w", k), writeReg_W, 5'(10 + k - 1));
                chk($sformatf("b2b%0d_rdata_w", k), readData_W, 64'(64'hA000 + k - 1));
                chk($sformatf("b2b%0d_valid_w", k), valid_W, 1);
            end
        end
        idle_e();
        tick();
        dm.rdata = 64'h5555;
        @(negedge clk);
        chk("b2b_tail_req", dm.req, 0);
        chk("b2b_tail_stall", stall_M, 0);
        chk("b2b_tail_writereg_w", writeReg_W, 13);
        chk("b2b_tail_rdata_w", readData_W, 64'hA003);
        tick();
        @(negedge clk);
        chk("stray_ack_valid_w", valid_W, 0);
        chk("stray_ack_rdata_w", readData_W, 64'hA003);
        dm.ack = 1'b0;

        // Reset asserted while an access is outstanding.
        set_e(1, 1, 0, 0, 1, 1, 0, 5'd4, 64'h0, 64'h40, 64'h0);
        tick();
        idle_e();
        tick();
        @(negedge clk);
        chk("mid_busy_req", dm.req, 1);
        chk("mid_busy_state", dut.state, BUSY);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_req", dm.req, 0);
        chk("mid_rst_stall", stall_M, 0);
        chk("mid_rst_addr", dm.addr, 0);
        chk("mid_rst_valid_w", valid_W, 0);
        chk("mid_rst_rdata_w", readData_W, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("post_rst_state", dut.state, IDLE);
        chk("post_rst_req", dm.req, 0);

        // Access that is never acknowledged; ADD waits in EX behind it.
        set_e(1, 1, 0, 0, 1, 1, 0, 5'd6, 64'h0, 64'h300, 64'h0);
        tick();
        set_e(1, 0, 0, 0, 1, 0, 0, 5'd8, 64'h0, 64'h11, 64'h0);
        dm.ack = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (stall_M && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
`ifdef MEM_TIMEOUT_EN
        chk("to_stall_cycles", cnt, 17);
        chk("to_abort_req", dm.req, 0);
        chk("to_abort_stall", stall_M, 0);
        @(posedge clk);
        #1;
        idle_e();
        @(negedge clk);
        chk("to_valid_w", valid_W, 1);
        chk("to_regwrite_w", RegWrite_W, 0);
        chk("to_writereg_w", writeReg_W, 6);
        chk("to_mem_err", mem_err, 1);
        chk("to_next_req", dm.req, 0);
        tick();
        @(negedge clk);
        chk("to_next_writereg_w", writeReg_W, 8);
        chk("to_next_regwrite_w", RegWrite_W, 1);
        chk("to_mem_err_sticky", mem_err, 1);
`else
        chk("wait_stall_cycles", cnt, 40);
        chk("wait_req", dm.req, 1);
        chk("wait_mem_err", mem_err, 0);
        dm.ack = 1'b1;
        dm.rdata = 64'h77AA;
        #1;
        chk("wait_ack_stall", stall_M, 0);
        @(posedge clk);
        #1;
        dm.ack = 1'b0;
        idle_e();
        @(negedge clk);
        chk("wait_rdata_w", readData_W, 64'h77AA);
        chk("wait_regwrite_w", RegWrite_W, 1);
        chk("wait_writereg_w", writeReg_W, 6);
        tick();
        @(negedge clk);
        chk("wait_next_writereg_w", writeReg_W, 8);
        chk("wait_mem_err_after", mem_err, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
